// File: rtl/clk_divider_multi.sv
// Multi-channel clock divider: per-channel programmable divisor, shadowed and applied only at a
// period boundary. Optional macro CLK_DIV_SYNC_EN adds sync_i to restart all running channels in phase.
module clk_divider_multi #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 28,
  parameter int DIV_RST = 10,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_10MHz_i,
  input  logic              rst_n_i,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic [N_CH-1:0]   en_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [WIDTH-1:0]  cfg_div_i,
  output logic [N_CH-1:0]   clk_div_o,
  output logic [N_CH-1:0]   tick_o,
  output logic [N_CH-1:0]   pending_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic sync_w;
`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // High phase lasts ceil(div/2) cycles; (div>>1)+div[0] never exceeds div, so no carry out.
  function automatic logic high_phase(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] div);
    return cnt < ((div >> 1) + WIDTH'(div[0]));
  endfunction

  function automatic logic last_cycle(input logic [WIDTH-1:0] cnt, input logic [WIDTH-1:0] div);
    return cnt == (div - ONE);
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH-1:0] shd_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
    logic             wr_w;
    logic [WIDTH-1:0] cnt_inc_w;

    // Indices at or above N_CH never match any channel, so such writes are dropped.
    assign wr_w      = cfg_we_i && (cfg_ch_i == CH_W'(i));
    assign cnt_inc_w = cnt_q + ONE;

    always_ff @(posedge clk_10MHz_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        // NOTE: divisor registers reset to DIV_RST too, so an unconfigured board still divides.
        state_q <= IDLE;
        cnt_q   <= '0;
        act_q   <= DIV_RST_W;
        shd_q   <= DIV_RST_W;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking semantics let a same-edge write keep pending set while the load
        // below still sees the pre-write shadow value.
        if (wr_w) begin
          shd_q  <= cfg_div_i;
          pend_q <= 1'b1;
        end

        unique case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (en_i[i] && (shd_q != '0)) begin
              state_q <= RUN;
              act_q   <= shd_q;
              clk_q   <= high_phase('0, shd_q);
              tick_q  <= last_cycle('0, shd_q);
              if (!wr_w) pend_q <= 1'b0;
            end else begin
              clk_q  <= 1'b0;
              tick_q <= 1'b0;
            end
          end

          RUN: begin
            if (!en_i[i] || (act_q == '0)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              clk_q   <= 1'b0;
              tick_q  <= 1'b0;
            end else if (sync_w || last_cycle(cnt_q, act_q)) begin
              // Period boundary (or forced restart): the shadow divisor becomes active here.
              cnt_q  <= '0;
              act_q  <= shd_q;
              clk_q  <= high_phase('0, shd_q);
              tick_q <= last_cycle('0, shd_q);
              if (!wr_w) pend_q <= 1'b0;
            end else begin
              cnt_q  <= cnt_inc_w;
              clk_q  <= high_phase(cnt_inc_w, act_q);
              tick_q <= last_cycle(cnt_inc_w, act_q);
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end

    assign clk_div_o[i] = clk_q;
    assign tick_o[i]    = tick_q;
    assign pending_o[i] = pend_q;
  end

endmodule
